// File: rtl/tmr_cfg_scrubber_if.sv
// Configuration write handshake: request held until a one-cycle acknowledge.
interface tmr_cfg_scrubber_if #(
    parameter int WIDTH = 6
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;

    modport master (
        output wr_en,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/tmr_cfg_scrubber.sv
// Triple-redundant config field with periodic majority scrub; TMR_SEU_INJECT_EN builds the SEU injection path.
// Write ack one cycle after acceptance; a held wr_en stalls up to 2 cycles while a scrub is in progress.
module tmr_cfg_scrubber #(
    parameter int               WIDTH        = 6,
    parameter int               SCRUB_PERIOD = 16,
    parameter int               ERRCNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic                clk,
    input  logic                rstn,
    tmr_cfg_scrubber_if.slave   wr,
    input  logic                err_clr,
    input  logic                inj_en,
    input  logic [1:0]          inj_copy,
    input  logic [WIDTH-1:0]    inj_mask,
    output logic [WIDTH-1:0]    cfg_q,
    output logic                scrub_busy,
    output logic                seu_flag,
    output logic [2:0]          mism_copy,
    output logic [ERRCNT_W-1:0] err_cnt
);
    localparam int              TMR_W    = $clog2(SCRUB_PERIOD);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REPAIR
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [WIDTH-1:0] c0, c1, c2;
    logic [WIDTH-1:0] c0_nxt, c1_nxt, c2_nxt;
    logic [2:0]       mism;
    logic             accept;

    assign cfg_q  = (c0 & c1) | (c0 & c2) | (c1 & c2);
    assign mism   = {c2 != cfg_q, c1 != cfg_q, c0 != cfg_q};
    assign accept = (state == IDLE) && wr.wr_en && !wr.wr_ack;

    // Copy values when neither a write nor a repair owns the registers.
`ifdef TMR_SEU_INJECT_EN
    always_comb begin
        c0_nxt = c0;
        c1_nxt = c1;
        c2_nxt = c2;
        if (inj_en) begin
            case (inj_copy)
                2'd0:    c0_nxt = c0 ^ inj_mask;
                2'd1:    c1_nxt = c1 ^ inj_mask;
                2'd2:    c2_nxt = c2 ^ inj_mask;
                default: ;
            endcase
        end
    end
`else
    logic unused_inj;
    assign unused_inj = ^{inj_en, inj_copy, inj_mask};
    assign c0_nxt = c0;
    assign c1_nxt = c1;
    assign c2_nxt = c2;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            timer      <= '0;
            c0         <= RESET_VAL;
            c1         <= RESET_VAL;
            c2         <= RESET_VAL;
            wr.wr_ack  <= 1'b0;
            seu_flag   <= 1'b0;
            scrub_busy <= 1'b0;
            mism_copy  <= '0;
            err_cnt    <= '0;
        end else begin
            wr.wr_ack <= 1'b0;
            seu_flag  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        c0        <= wr.wr_data;
                        c1        <= wr.wr_data;
                        c2        <= wr.wr_data;
                        wr.wr_ack <= 1'b1;
                        timer     <= '0;
                    end else begin
                        c0 <= c0_nxt;
                        c1 <= c1_nxt;
                        c2 <= c2_nxt;
                        if (timer == TMR_LAST) begin
                            state      <= CHECK;
                            scrub_busy <= 1'b1;
                            timer      <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    mism_copy <= mism;
                    c0        <= c0_nxt;
                    c1        <= c1_nxt;
                    c2        <= c2_nxt;
                    if (|mism) begin
                        state <= REPAIR;
                    end else begin
                        state      <= IDLE;
                        scrub_busy <= 1'b0;
                    end
                end
                REPAIR: begin
                    c0         <= cfg_q;
                    c1         <= cfg_q;
                    c2         <= cfg_q;
                    seu_flag   <= 1'b1;
                    state      <= IDLE;
                    scrub_busy <= 1'b0;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    scrub_busy <= 1'b0;
                end
            endcase
            // A clear overrides any increment scheduled on the same edge.
            if (err_clr) begin
                err_cnt <= '0;
            end
        end
    end
endmodule
